// File: rtl/seven_seg_scan_controller.sv
// Scan sequencer for a 4-digit multiplexed seven-segment display.
// Active-low anodes/cathodes, blanking before each digit, frame-synchronous value commit.
module seven_seg_scan_controller #(
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS     = 1000
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [15:0] value,
  input  logic        value_valid,
  output logic        value_ready,
  input  logic [3:0]  digit_en,
  input  logic        lz_blank,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        frame_done
);

  localparam int CW = (TICKS_PER_DIGIT > 2) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam logic [CW-1:0] LAST  = CW'(TICKS_PER_DIGIT - 1);
  localparam logic [CW-1:0] BLANK = CW'(BLANK_TICKS);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'b1000000;
      4'h1: hex_to_seg = 7'b1111001;
      4'h2: hex_to_seg = 7'b0100100;
      4'h3: hex_to_seg = 7'b0110000;
      4'h4: hex_to_seg = 7'b0011001;
      4'h5: hex_to_seg = 7'b0010010;
      4'h6: hex_to_seg = 7'b0000010;
      4'h7: hex_to_seg = 7'b1111000;
      4'h8: hex_to_seg = 7'b0000000;
      4'h9: hex_to_seg = 7'b0010000;
      4'hA: hex_to_seg = 7'b0001000;
      4'hB: hex_to_seg = 7'b0000011;
      4'hC: hex_to_seg = 7'b1000110;
      4'hD: hex_to_seg = 7'b0100001;
      4'hE: hex_to_seg = 7'b0000110;
      default: hex_to_seg = 7'b0001110;
    endcase
  endfunction

  // Digit k is leading-zero blanked when it and every higher nibble are zero; digit 0 never is.
  function automatic logic [3:0] lz_mask(input logic [15:0] v, input logic en);
    logic [3:0] z;
    z[3] = (v[15:12] == 4'h0);
    z[2] = z[3] && (v[11:8] == 4'h0);
    z[1] = z[2] && (v[7:4] == 4'h0);
    z[0] = 1'b0;
    lz_mask = en ? z : 4'b0000;
  endfunction

  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    idx, idx_nxt;
  logic          pend, pend_nxt;
  logic [15:0]   pend_val;
  logic [3:0]    pend_en;
  logic          pend_lz;
  logic [15:0]   disp_val, disp_val_nxt;
  logic [3:0]    disp_en, disp_en_nxt;
  logic          disp_lz, disp_lz_nxt;
  logic [3:0]    anode_nxt, lzb;
  logic [6:0]    seg_nxt;
  logic          fd_nxt, frame_end, capture, show;

  assign value_ready = ~pend;
  assign capture     = value_valid && ~pend;

  always_comb begin
    cnt_nxt      = cnt + CW'(1);
    idx_nxt      = idx;
    frame_end    = (cnt == LAST) && (idx == 2'd3);
    pend_nxt     = pend;
    disp_val_nxt = disp_val;
    disp_en_nxt  = disp_en;
    disp_lz_nxt  = disp_lz;
    if (cnt == LAST) begin
      cnt_nxt = '0;
      idx_nxt = idx + 2'd1;
    end
    // A commit uses the pending flag as it stood before this edge, so a same-edge capture waits a frame.
    if (frame_end && pend) begin
      disp_val_nxt = pend_val;
      disp_en_nxt  = pend_en;
      disp_lz_nxt  = pend_lz;
      pend_nxt     = 1'b0;
    end else if (capture) begin
      pend_nxt = 1'b1;
    end
    // Outputs are precomputed from the next state so the registers show the current slot.
    lzb       = lz_mask(disp_val_nxt, disp_lz_nxt);
    show      = (cnt_nxt >= BLANK) && disp_en_nxt[idx_nxt] && ~lzb[idx_nxt];
    anode_nxt = show ? ~(4'b0001 << idx_nxt) : 4'b1111;
    seg_nxt   = show ? hex_to_seg(disp_val_nxt[{idx_nxt, 2'b00} +: 4]) : 7'h7F;
    fd_nxt    = (cnt_nxt == LAST) && (idx_nxt == 2'd3);
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      cnt        <= '0;
      idx        <= 2'd0;
      pend       <= 1'b0;
      disp_val   <= 16'h0000;
      disp_en    <= 4'b1111;
      disp_lz    <= 1'b0;
      anode      <= 4'b1111;
      seg        <= 7'h7F;
      frame_done <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      pend       <= pend_nxt;
      disp_val   <= disp_val_nxt;
      disp_en    <= disp_en_nxt;
      disp_lz    <= disp_lz_nxt;
      anode      <= anode_nxt;
      seg        <= seg_nxt;
      frame_done <= fd_nxt;
    end
  end

  // Pending payload is only meaningful while the pending flag is set.
  always_ff @(posedge clk) begin
    if (capture) begin
      pend_val <= value;
      pend_en  <= digit_en;
      pend_lz  <= lz_blank;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Directed bench for seven_seg_scan_controller with TICKS_PER_DIGIT=8, BLANK_TICKS=2.
// One continuous timeline; cycle 0 is the first cycle after reset release.
module tb_seven_seg_scan_controller;

  logic        clk = 1'b0;
  logic        Reset;
  logic [15:0] value;
  logic        value_valid;
  logic        value_ready;
  logic [3:0]  digit_en;
  logic        lz_blank;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        frame_done;

  seven_seg_scan_controller #(.TICKS_PER_DIGIT(8), .BLANK_TICKS(2)) dut (
    .clk(clk), .Reset(Reset), .value(value), .value_valid(value_valid),
    .value_ready(value_ready), .digit_en(digit_en), .lz_blank(lz_blank),
    .anode(anode), .seg(seg), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] sg;
    logic       fd;
    logic       rdy;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void add(int c, logic [3:0] a, logic [6:0] s, logic f, logic r);
    vec_t v;
    v.cyc = c; v.an = a; v.sg = s; v.fd = f; v.rdy = r;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [3:0] a, logic [6:0] s, logic f, logic r);
    n_tests++;
    if (anode !== a || seg !== s || frame_done !== f || value_ready !== r) begin
      n_fail++;
      $display("FAIL %s: got anode=%b seg=%b fd=%b rdy=%b, want anode=%b seg=%b fd=%b rdy=%b",
               name, anode, seg, frame_done, value_ready, a, s, f, r);
    end
  endtask

  task automatic offer(logic [15:0] v, logic [3:0] en, logic lz);
    value = v; digit_en = en; lz_blank = lz; value_valid = 1'b1;
  endtask

  initial begin
    int ptr;
    int bad_f3;
    int bad_f4;
    // frame 0: display 0000
    add(0, 4'hF, 7'h7F, 0, 1); add(1, 4'hF, 7'h7F, 0, 1); add(2, 4'hE, 7'h40, 0, 1);
    add(5, 4'hE, 7'h40, 0, 1); add(6, 4'hE, 7'h40, 0, 0); add(7, 4'hE, 7'h40, 0, 0);
    add(8, 4'hF, 7'h7F, 0, 0); add(9, 4'hF, 7'h7F, 0, 0); add(10, 4'hD, 7'h40, 0, 0);
    add(15, 4'hD, 7'h40, 0, 0); add(16, 4'hF, 7'h7F, 0, 0); add(18, 4'hB, 7'h40, 0, 0);
    add(23, 4'hB, 7'h40, 0, 0); add(26, 4'h7, 7'h40, 0, 0); add(30, 4'h7, 7'h40, 0, 0);
    add(31, 4'h7, 7'h40, 1, 0);
    // frame 1: 12AF
    add(32, 4'hF, 7'h7F, 0, 1); add(33, 4'hF, 7'h7F, 0, 1); add(34, 4'hE, 7'h0E, 0, 1);
    add(42, 4'hD, 7'h08, 0, 0); add(50, 4'hB, 7'h24, 0, 0); add(58, 4'h7, 7'h79, 0, 0);
    add(63, 4'h7, 7'h79, 1, 0);
    // frame 2: 0050 with leading-zero blanking
    add(64, 4'hF, 7'h7F, 0, 1); add(66, 4'hE, 7'h40, 0, 0); add(74, 4'hD, 7'h12, 0, 0);
    add(82, 4'hF, 7'h7F, 0, 0); add(90, 4'hF, 7'h7F, 0, 0); add(95, 4'hF, 7'h7F, 1, 0);
    // frame 3: 0000 with leading-zero blanking
    add(96, 4'hF, 7'h7F, 0, 1); add(98, 4'hE, 7'h40, 0, 1); add(106, 4'hF, 7'h7F, 0, 0);
    add(114, 4'hF, 7'h7F, 0, 0); add(122, 4'hF, 7'h7F, 0, 0); add(127, 4'hF, 7'h7F, 1, 0);
    // frames 4-5: 8888 with mask 0101
    add(130, 4'hE, 7'h00, 0, 1); add(138, 4'hF, 7'h7F, 0, 1); add(146, 4'hB, 7'h00, 0, 1);
    add(154, 4'hF, 7'h7F, 0, 1); add(159, 4'hF, 7'h7F, 1, 1); add(160, 4'hF, 7'h7F, 0, 0);
    add(162, 4'hE, 7'h00, 0, 0); add(170, 4'hF, 7'h7F, 0, 0);
    // frame 6: 1234 (loaded on the frame_done edge of frame 4)
    add(194, 4'hE, 7'h19, 0, 1); add(202, 4'hD, 7'h30, 0, 0); add(211, 4'hB, 7'h24, 0, 0);
    // reset in cycle 212; 213 is the new cycle 0
    add(213, 4'hF, 7'h7F, 0, 1); add(214, 4'hF, 7'h7F, 0, 1); add(215, 4'hE, 7'h40, 0, 1);
    add(223, 4'hD, 7'h40, 0, 1); add(244, 4'h7, 7'h40, 1, 1); add(247, 4'hE, 7'h40, 0, 1);

    Reset = 1'b0; value = 16'h0; value_valid = 1'b0; digit_en = 4'hF; lz_blank = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 4'hF, 7'h7F, 0, 1);
    Reset = 1'b1;

    ptr = 0; bad_f3 = 0; bad_f4 = 0;
    for (int cyc = 0; cyc <= 250; cyc++) begin
      case (cyc)
        5:   offer(16'h12AF, 4'b1111, 1'b0);
        10:  offer(16'h3333, 4'b1111, 1'b0);
        40:  offer(16'h0050, 4'b1111, 1'b1);
        65:  offer(16'h0000, 4'b1111, 1'b1);
        100: offer(16'h8888, 4'b0101, 1'b0);
        159: offer(16'h1234, 4'b1111, 1'b0);
        200: offer(16'h5555, 4'b1111, 1'b0);
        212: Reset = 1'b0;
        213: Reset = 1'b1;
        default: value_valid = 1'b0;
      endcase
      while (ptr < vecs.size() && vecs[ptr].cyc == cyc) begin
        check($sformatf("cyc%0d", cyc), vecs[ptr].an, vecs[ptr].sg, vecs[ptr].fd, vecs[ptr].rdy);
        ptr++;
      end
      if (cyc >= 96 && cyc <= 127 && anode != 4'hF && anode != 4'hE) bad_f3++;
      if (cyc >= 128 && cyc <= 159 && (anode == 4'hD || anode == 4'h7)) bad_f4++;
      @(posedge clk);
      #1;
    end

    n_tests++;
    if (bad_f3 != 0) begin
      n_fail++;
      $display("FAIL frame3_only_digit0: got %0d cycles with other anodes, want 0", bad_f3);
    end
    n_tests++;
    if (bad_f4 != 0) begin
      n_fail++;
      $display("FAIL frame4_masked_digits: got %0d cycles with anode 1101/0111, want 0", bad_f4);
    end
    n_tests++;
    if (ptr != vecs.size()) begin
      n_fail++;
      $display("FAIL table_walk: got %0d vectors applied, want %0d", ptr, vecs.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_controller.md
Name: seven_seg_scan_controller

Overview:
Sequencer for the 4-digit multiplexed seven-segment display.
- Generates the per-digit scan timing from the system clock.
- Walks a one-hot active-low anode select across digits 0..3.
- Inserts a blanking interval before every digit switch to suppress ghosting.
- Drives the active-low segment cathodes from a double-buffered 16-bit hex value.
- The new value is committed only at frame boundaries, so the display never tears.

Parameters:
TICKS_PER_DIGIT, 100000, clk cycles per digit slot (1 ms at 100 MHz); legal range >= 2
BLANK_TICKS, 1000, cycles at the start of each slot with all anodes off; legal range 1 <= BLANK_TICKS < TICKS_PER_DIGIT

Ports:
clk  in  1  system clock; all logic on rising edge
Reset  in  1  synchronous, active-low reset
value  in  16  four hex nibbles; [3:0] = digit 0 (rightmost)
value_valid  in  1  producer offers value/digit_en/lz_blank
value_ready  out  1  controller can accept a new value
digit_en  in  4  per-digit enable mask, sampled with value
lz_blank  in  1  leading-zero blanking enable, sampled with value
anode  out  4  digit select, active-low, at most one bit low
seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low
frame_done  out  1  one-cycle pulse at end of digit 3 slot

Behaviour:
Reset
- On a clk edge with Reset=0: slot counter=0, digit index=0.
- Pending flag=0. Display value=16'h0000, display mask=4'b1111, display lz=0.
- Outputs: anode=4'b1111, seg=7'h7F, frame_done=0, value_ready=1.
- Reset mid-operation discards the pending value and restarts at digit 0, cycle 0.

Scan timing
- First cycle with Reset=1 is cycle 0 of the digit 0 slot.
- Slot counter c runs 0..TICKS_PER_DIGIT-1, then wraps to 0 and the digit index increments mod 4.
- All outputs are registered and reflect the current (c, digit index) state.
- c < BLANK_TICKS (BLANK): anode=4'b1111, seg=7'h7F.
- c >= BLANK_TICKS (SHOW): anode[idx]=0 and seg=decode(nibble idx), unless the digit is suppressed.
- A suppressed digit keeps anode=4'b1111 and seg=7'h7F for the whole slot.
- Suppressed means: mask[idx]=0, or the digit is leading-zero blanked.
- Leading-zero blanking (lz=1): digit k in 3..1 is blanked when nibble k and all higher nibbles are 0. Digit 0 is never lz-blanked.
- Frame period = 4*TICKS_PER_DIGIT cycles.
- frame_done=1 exactly in the cycle where idx=3 and c=TICKS_PER_DIGIT-1.

Decode (hex to active-low seg)
0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110

Handshake / double buffer
- value_ready = NOT pending.
- On an edge with value_valid=1 and value_ready=1: capture value/digit_en/lz_blank into the pending buffer and set pending. value_ready=0 from the next cycle.
- While value_ready=0, value_valid is ignored and the pending contents are held.
- On the frame_done edge with pending=1 (as registered before the edge): copy pending to the display registers and clear pending. value_ready=1 from the next cycle. The new value is shown from digit 0 of the following frame.
- Simultaneous case: a capture on the same edge as frame_done, with pending=0, only loads pending. It is committed at the next frame_done.
- With value_valid held high, at most one value is accepted per frame.

Test Plan:
Use TICKS_PER_DIGIT=8 and BLANK_TICKS=2 throughout.
1. Reset released at cycle 0 -> anode=1111 in cycles 0-1; 1110 in 2-7; 1111 in 8-9; 1101 in 10-15; 1011 in 18-23; 0111 in 26-31. seg=1000000 in shown cycles. frame_done only in cycle 31, then repeats every 32 cycles. value_ready=1.
2. value=16'h12AF, digit_en=1111, lz=0, valid at cycle 5 -> value_ready=0 from cycle 6. Frame 0 still shows 0s. value_ready=1 at cycle 32. Frame 1 seg: digit0=0001110, digit1=0001000, digit2=0100100, digit3=1111001.
3. Second valid (16'h3333) at cycle 10 while ready=0 -> ignored. Frame 1 shows 12AF, not 3333.
4. value=16'h0050 with lz=1, committed -> digits 3 and 2 keep anode high and seg=7F. Digit1 shows 0010010, digit0 shows 1000000. Then value=16'h0000 with lz=1 -> only digit0 is lit, showing 1000000.
5. digit_en=4'b0101, value=16'h8888 -> anode never takes 1101 or 0111. Digits 0 and 2 show 0000000. frame_done timing is unchanged.
6. Pending load accepted, then Reset=0 for one cycle during the digit 2 SHOW slot -> next cycle anode=1111, seg=7F, value_ready=1. Display stays 0000. Scan restarts at digit 0, cycle 0.
